// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes packed into one instruction word, and the resulting word width.
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 8 * BYTES_PER_WORD;

  // Clamp a requested word count to the memory capacity (2^addr_width words).
  function automatic logic [31:0] sat_count(input logic [31:0] count,
                                            input int          addr_width);
    logic [31:0] cap;
    cap = 32'd1 << addr_width;
    return (count > cap) ? cap : count;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: shifts bytes in from the low end so the first
// byte of a word ends up in the most significant lane.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic                  Shift,
  input  logic [7:0]            ByteIn,
  output logic [WORD_WIDTH-1:0] Word,
  output logic                  Full
);

  localparam int                CNT_W     = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt;

  // Shift register and byte counter; Clear wins over Shift so a new load
  // always starts from an empty word.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (Reset) begin
      Word     <= '0;
      byte_cnt <= '0;
    end else if (Clear) begin
      Word     <= '0;
      byte_cnt <= '0;
    end else if (Shift) begin
      Word     <= {Word[WORD_WIDTH-9:0], ByteIn};
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // The counter wraps to 0 on its own after the last byte of a word.
  assign Full = Shift && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: accepts a byte stream, packs four
// bytes per word and writes the words to sequential addresses from 0 while
// holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   WordCount,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemData,
  output logic                  CpuHold,
  output logic                  Done
);

  // Address and count carry one extra bit so a full-capacity load can be
  // compared against 2^ADDR_WIDTH without wrapping.
  localparam int               CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      addr;
  logic [CNT_W-1:0]      count;
  logic                  start_load;
  logic                  accept;
  logic                  full;
  logic [WORD_WIDTH-1:0] word;

  // A byte is only taken in LOAD, which is exactly when ByteReady is high.
  assign start_load = (state == IDLE) && Start;
  assign accept     = (state == LOAD) && ByteValid;

  byte_packer u_packer (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (start_load),
    .Shift  (accept),
    .ByteIn (ByteIn),
    .Word   (word),
    .Full   (full)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Latched word count and current word address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      addr  <= '0;
    end else if (start_load) begin
      count <= CNT_W'(sat_count(32'(WordCount), ADDR_WIDTH));
      addr  <= '0;
    end else if (state == WRITE) begin
      addr <= addr + ONE;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    ByteReady  = 1'b0;
    MemWrite   = 1'b0;
    CpuHold    = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_next = (WordCount == '0) ? DONE : LOAD;
      end
      LOAD: begin
        ByteReady = 1'b1;
        CpuHold   = 1'b1;
        if (full) state_next = WRITE;
      end
      WRITE: begin
        MemWrite   = 1'b1;
        CpuHold    = 1'b1;
        state_next = ((addr + ONE) == count) ? DONE : LOAD;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign MemAddr = addr[ADDR_WIDTH-1:0];
  assign MemData = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: default-width instance for the main
// scenarios, ADDR_WIDTH=2 instance for count saturation.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (ADDR_WIDTH = 8)
  logic        rst, start, byte_valid, byte_ready, mem_write, cpu_hold, done;
  logic [8:0]  word_count;
  logic [7:0]  byte_in, mem_addr;
  logic [31:0] mem_data;

  // Small instance (ADDR_WIDTH = 2)
  logic        s_rst, s_start, s_byte_valid, s_byte_ready, s_mem_write, s_cpu_hold, s_done;
  logic [2:0]  s_word_count;
  logic [7:0]  s_byte_in;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_data;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .WordCount(word_count),
    .ByteIn(byte_in), .ByteValid(byte_valid), .ByteReady(byte_ready),
    .MemWrite(mem_write), .MemAddr(mem_addr), .MemData(mem_data),
    .CpuHold(cpu_hold), .Done(done)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut_small (
    .Clk(clk), .Reset(s_rst), .Start(s_start), .WordCount(s_word_count),
    .ByteIn(s_byte_in), .ByteValid(s_byte_valid), .ByteReady(s_byte_ready),
    .MemWrite(s_mem_write), .MemAddr(s_mem_addr), .MemData(s_mem_data),
    .CpuHold(s_cpu_hold), .Done(s_done)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream [0:15];
  int          stream_idx;

  // Captured memory writes, one entry per MemWrite cycle.
  logic [7:0]  cap_addr[$];
  logic [31:0] cap_data[$];
  logic [1:0]  s_cap_addr[$];
  logic [31:0] s_cap_data[$];

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_data);
    end
    if (s_mem_write === 1'b1) begin
      s_cap_addr.push_back(s_mem_addr);
      s_cap_data.push_back(s_mem_data);
    end
  end

  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        stream[4*k+j] = w[k][31-8*j -: 8];
    stream_idx = 0;
  endtask

  task automatic start_load(input logic [8:0] cnt);
    @(negedge clk);
    start      = 1'b1;
    word_count = cnt;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Present n bytes from the stream; a byte advances only when it is offered
  // in a cycle where the loader is ready. Valid stays high through WRITE.
  task automatic feed_bytes(input int n, input bit gaps, output bit timeout);
    int fed    = 0;
    int cycles = 0;
    timeout = 1'b0;
    while (fed < n && !timeout) begin
      @(negedge clk);
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = (stream_idx < 16) ? stream[stream_idx] : 8'h00;
      if (byte_valid && byte_ready) begin
        fed++;
        stream_idx++;
      end
      cycles++;
      if (cycles > 400) timeout = 1'b1;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timeout);
    timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({byte_ready, mem_write, cpu_hold, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=0000", {byte_ready, mem_write, cpu_hold, done});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus got addr=%h data=%h exp 00/00000000", mem_addr, mem_data);
    end
    total++;
    if ({s_byte_ready, s_mem_write, s_cpu_hold, s_done} !== 4'b0000 || s_mem_addr !== 2'b00) begin
      bad++;
      $display("FAIL reset_small got ctl=%b addr=%h exp 0000/0",
               {s_byte_ready, s_mem_write, s_cpu_hold, s_done}, s_mem_addr);
    end
    rst = 1'b0; s_rst = 1'b0;
  endtask

  // Cycle-exact two-word load with ByteValid held high.
  task automatic test_basic();
    logic [3:0]  exp_ctl;
    logic [31:0] exp_w [2];
    int          idx = 0;
    exp_w[0] = 32'h20080005;
    exp_w[1] = 32'h24090007;
    set_words(exp_w[0], exp_w[1], 32'h0, 32'h0);
    cap_addr.delete(); cap_data.delete();
    @(negedge clk);
    start = 1'b1; word_count = 9'd2; byte_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp_ctl = {((c >= 1 && c <= 4) || (c >= 6 && c <= 9)),
                 (c == 5 || c == 10), (c >= 1 && c <= 10), (c == 11)};
      total++;
      if ({byte_ready, mem_write, cpu_hold, done} !== exp_ctl) begin
        bad++;
        $display("FAIL basic_ctl cycle=%0d got=%b exp=%b", c,
                 {byte_ready, mem_write, cpu_hold, done}, exp_ctl);
      end
      if (c == 5 || c == 10) begin
        total++;
        if (mem_addr !== ((c == 5) ? 8'd0 : 8'd1) || mem_data !== exp_w[(c == 5) ? 0 : 1]) begin
          bad++;
          $display("FAIL basic_write cycle=%0d got addr=%h data=%h exp addr=%h data=%h", c,
                   mem_addr, mem_data, (c == 5) ? 8'd0 : 8'd1, exp_w[(c == 5) ? 0 : 1]);
        end
      end
      if (byte_ready === 1'b1) begin
        byte_in = (idx < 8) ? stream[idx] : 8'h00;
        idx++;
      end
    end
    byte_valid = 1'b0;
    total++;
    if (cap_addr.size() !== 2) begin
      bad++;
      $display("FAIL basic_write_count got=%0d exp=2", cap_addr.size());
    end
  endtask

  task automatic test_zero_count();
    cap_addr.delete(); cap_data.delete();
    @(negedge clk);
    start = 1'b1; word_count = 9'd0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({byte_ready, mem_write, cpu_hold, done} !== {3'b000, (c == 1)}) begin
        bad++;
        $display("FAIL zero_ctl cycle=%0d got=%b exp=%b", c,
                 {byte_ready, mem_write, cpu_hold, done}, {3'b000, (c == 1)});
      end
    end
    total++;
    if (cap_addr.size() !== 0) begin
      bad++;
      $display("FAIL zero_writes got=%0d exp=0", cap_addr.size());
    end
  endtask

  task automatic test_gaps();
    logic [31:0] exp_w [3];
    bit          to;
    exp_w[0] = 32'h8C010004; exp_w[1] = 32'hAC220008; exp_w[2] = 32'h1000FFFF;
    set_words(exp_w[0], exp_w[1], exp_w[2], 32'h0);
    cap_addr.delete(); cap_data.delete();
    start_load(9'd3);
    feed_bytes(12, 1'b1, to);
    total++;
    if (to) begin bad++; $display("FAIL gaps_feed got=timeout exp=12 bytes"); end
    wait_done(20, to);
    total++;
    if (to) begin bad++; $display("FAIL gaps_done got=timeout exp=done"); end
    total++;
    if (cap_addr.size() !== 3) begin
      bad++;
      $display("FAIL gaps_write_count got=%0d exp=3", cap_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cap_addr[i] !== 8'(i) || cap_data[i] !== exp_w[i]) begin
          bad++;
          $display("FAIL gaps_word%0d got addr=%h data=%h exp addr=%h data=%h", i,
                   cap_addr[i], cap_data[i], 8'(i), exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit to;
    set_words(32'h20080005, 32'h24090007, 32'h0, 32'h0);
    cap_addr.delete(); cap_data.delete();
    start_load(9'd2);
    feed_bytes(7, 1'b0, to);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({byte_ready, mem_write, cpu_hold, done} !== 4'b0000) begin
      bad++;
      $display("FAIL async_rst_ctl got=%b exp=0000", {byte_ready, mem_write, cpu_hold, done});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_data !== 32'h0) begin
      bad++;
      $display("FAIL async_rst_bus got addr=%h data=%h exp 00/00000000", mem_addr, mem_data);
    end
    total++;
    if (cap_addr.size() !== 1 || cap_data[0] !== 32'h20080005) begin
      bad++;
      $display("FAIL async_rst_prior got count=%0d exp 1 word 20080005", cap_addr.size());
    end
    @(negedge clk);
    rst = 1'b0;
    set_words(32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    cap_addr.delete(); cap_data.delete();
    start_load(9'd1);
    feed_bytes(4, 1'b0, to);
    wait_done(10, to);
    total++;
    if (to || cap_addr.size() !== 1) begin
      bad++;
      $display("FAIL async_rst_reload got count=%0d timeout=%0d exp 1 word", cap_addr.size(), to);
    end else begin
      total++;
      if (cap_addr[0] !== 8'h00 || cap_data[0] !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL async_rst_reload_word got addr=%h data=%h exp 00/deadbeef",
                 cap_addr[0], cap_data[0]);
      end
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    set_words(32'h11223344, 32'h55667788, 32'h0, 32'h0);
    cap_addr.delete(); cap_data.delete();
    start_load(9'd2);
    feed_bytes(2, 1'b0, to);
    start = 1'b1; word_count = 9'd1;
    @(negedge clk);
    start = 1'b0; word_count = 9'd0;
    feed_bytes(6, 1'b0, to);
    wait_done(10, to);
    total++;
    if (to || cap_addr.size() !== 2) begin
      bad++;
      $display("FAIL restart_count got=%0d timeout=%0d exp=2", cap_addr.size(), to);
    end else begin
      total++;
      if (cap_addr[0] !== 8'h00 || cap_data[0] !== 32'h11223344 ||
          cap_addr[1] !== 8'h01 || cap_data[1] !== 32'h55667788) begin
        bad++;
        $display("FAIL restart_words got %h@%h %h@%h exp 11223344@00 55667788@01",
                 cap_data[0], cap_addr[0], cap_data[1], cap_addr[1]);
      end
    end
  endtask

  task automatic test_saturate();
    int idx        = 0;
    int done_cycle = -1;
    s_cap_addr.delete(); s_cap_data.delete();
    for (int i = 0; i < 16; i++) stream[i] = 8'(i);
    @(negedge clk);
    s_start = 1'b1; s_word_count = 3'd7; s_byte_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_done === 1'b1 && done_cycle < 0) done_cycle = c;
      if (s_byte_ready === 1'b1) begin
        s_byte_in = (idx < 16) ? stream[idx] : 8'h00;
        idx++;
      end
    end
    s_byte_valid = 1'b0;
    total++;
    if (done_cycle != 21) begin
      bad++;
      $display("FAIL sat_done_cycle got=%0d exp=21", done_cycle);
    end
    total++;
    if (s_cap_addr.size() !== 4) begin
      bad++;
      $display("FAIL sat_write_count got=%0d exp=4", s_cap_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s_cap_addr[i] !== 2'(i) ||
            s_cap_data[i] !== {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}) begin
          bad++;
          $display("FAIL sat_word%0d got addr=%h data=%h exp addr=%h data=%h", i,
                   s_cap_addr[i], s_cap_data[i], 2'(i),
                   {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_word_count = '0; s_byte_in = '0; s_byte_valid = 1'b0;
    stream_idx = 0;
    test_reset();
    test_basic();
    test_zero_count();
    test_gaps();
    test_async_reset();
    test_restart_ignored();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that writes 32-bit instruction words into the CPU's instruction memory: the write-side counterpart to the CPU's instruction fetch path. It accepts a byte stream on a valid/ready handshake, packs four bytes per word big-endian, and issues one memory write per word at sequential word addresses from 0. `CpuHold` stalls the CPU for the duration of the load. It sits between a host byte source (bench or UART receiver) and the instruction memory write port.

## Interface
- `ADDR_WIDTH`, default 8: instruction memory word-address width; capacity is 2^ADDR_WIDTH words.

- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `WordCount`  in  ADDR_WIDTH+1  number of words to load; sampled with `Start`.
- `ByteIn`  in  8  incoming program byte.
- `ByteValid`  in  1  `ByteIn` is valid.
- `ByteReady`  out  1  loader accepts a byte this cycle.
- `MemWrite`  out  1  instruction memory write enable, one cycle per word.
- `MemAddr`  out  ADDR_WIDTH  word address of the write.
- `MemData`  out  32  packed instruction word.
- `CpuHold`  out  1  CPU stall/hold request while loading.
- `Done`  out  1  one-cycle pulse at load completion.

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: `ByteReady`=0, `CpuHold`=0. When `Start`=1, latch the count (saturated to 2^ADDR_WIDTH), clear the address and byte counters, then:
  - go to DONE if the count is 0;
  - otherwise go to LOAD.
- LOAD: `ByteReady`=1, `CpuHold`=1.
  - A byte is accepted on each edge with `ByteValid` && `ByteReady`.
  - Packing is big-endian: byte 0 goes to [31:24], byte 3 to [7:0].
  - The 2-bit byte counter advances per accepted byte.
  - On acceptance of byte 3, go to WRITE.
- WRITE: `MemWrite`=1, `MemAddr`=current word address, `MemData`=packed word, `ByteReady`=0, `CpuHold`=1.
  - Next edge: increment the address.
  - If address+1 equals the latched count, go to DONE; otherwise go to LOAD with the byte counter at 0.
- DONE: `Done`=1, `CpuHold`=0, `ByteReady`=0; go to IDLE next edge.
- `Start` outside IDLE is ignored. `WordCount` changes after sampling are ignored.
- `ByteValid` while `ByteReady`=0 is not consumed; the source holds the byte.
- Address arithmetic is ADDR_WIDTH+1 bits internally. `MemAddr` is the low ADDR_WIDTH bits. With count 2^ADDR_WIDTH, the final write goes to address 2^ADDR_WIDTH−1, then DONE, with no wrap-around.

## Timing
- Reset values: state IDLE; `ByteReady`=0, `MemWrite`=0, `MemAddr`=0, `MemData`=0, `CpuHold`=0, `Done`=0; all counters 0.
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Start → first `ByteReady`=1: 1 cycle. 4th byte accepted → `MemWrite` pulse: next cycle.
- Throughput with `ByteValid` held at 1: 5 cycles per word (4 accepts + 1 write). An N-word load takes 5N cycles from LOAD entry to DONE.
- Last `MemWrite` cycle → `Done` pulse: next cycle. `CpuHold` falls on the same edge `Done` rises.
- Reset mid-load: immediate return to IDLE with reset values. Words already written stay in memory; a partially packed word is discarded.
- `ByteValid` gaps in LOAD only stretch the load; packed bytes are retained.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LOAD, WRITE, DONE);
  - constant `BYTES_PER_WORD`=4;
  - function for count saturation.
- One sub-module, `byte_packer`: 32-bit shift register plus 2-bit byte counter, with ports `Clk`, `Reset`, `Clear`, `Shift`, `ByteIn`, `Word`, `Full` (asserted when byte 3 is shifted in). The FSM stays in `imem_loader`.

## Test plan
- Reset, then `Start` with `WordCount`=2 and bytes 20 08 00 05 24 09 00 07 streamed with `ByteValid`=1 → writes 0x20080005 @0 and 0x24090007 @1, each a single-cycle `MemWrite`; `Done` at cycle 11 after `Start`; `CpuHold`=1 from cycle 1 to 10.
- `WordCount`=0 → DONE one cycle after `Start`; no `MemWrite`; `CpuHold` never asserts.
- Random `ByteValid` gaps (≈50% duty) with a 3-word load → same three words and addresses as the gap-free run; no byte is dropped or duplicated.
- `Reset` asserted asynchronously after byte 2 of word 1 → all outputs at reset values before the next edge. A subsequent load of 1 word writes @0 with fresh data.
- `Start` pulsed again during LOAD, and `ByteValid` held in WRITE → no restart; WRITE consumes no byte; the word sequence is unchanged.
- `ADDR_WIDTH`=2, `WordCount`=7 → saturates to 4 writes at addresses 0–3, then `Done`; `MemAddr` never wraps.
